// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmitter.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        BITS,
        ACK,
        WAIT_REL
    } ps2_state_e;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one PS/2 line plus falling-edge detect.
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync_o,
    output logic fall_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = din;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Idle bus level is high, so reset to 1 to avoid a false edge on release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_o = sync_q;
    assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (inhibit, request, 11-bit frame, ACK).
// Define PS2_TX_ACK_CHECK_EN to turn a missing device ACK into an err pulse.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYC = 12000,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int IW = $clog2(INHIBIT_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic clk_sync, clk_fall, data_sync, data_fall_unused;

    ps2_line_sync u_clk_sync (
        .clk    (clk),
        .rst    (rst),
        .din    (ps2_clk_in),
        .sync_o (clk_sync),
        .fall_o (clk_fall)
    );

    ps2_line_sync u_data_sync (
        .clk    (clk),
        .rst    (rst),
        .din    (ps2_data_in),
        .sync_o (data_sync),
        .fall_o (data_fall_unused)
    );

    ps2_state_e    state_q, state_d;
    logic [7:0]    data_q, data_d;
    logic          par_q, par_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic          drv_q, drv_d;
    logic [IW-1:0] inh_cnt_q, inh_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
`ifdef PS2_TX_ACK_CHECK_EN
    logic          ack_q, ack_d;
`endif

    logic counting, timeout, inh_last;

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        par_d     = par_q;
        bit_cnt_d = bit_cnt_q;
        drv_d     = drv_q;
        inh_cnt_d = inh_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
`ifdef PS2_TX_ACK_CHECK_EN
        ack_d     = ack_q;
`endif
        tx_ready    = 1'b0;
        busy        = 1'b1;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        done        = 1'b0;
        err         = 1'b0;

        counting = (state_q == REQ) || (state_q == BITS) ||
                   (state_q == ACK) || (state_q == WAIT_REL);
        timeout  = (tmo_cnt_q == TW'(TIMEOUT_CYC));
        inh_last = (inh_cnt_q == IW'(INHIBIT_CYC - 1));

        if (counting)
            tmo_cnt_d = clk_fall ? '0 : tmo_cnt_q + TW'(1);

        case (state_q)
            IDLE: begin
                tx_ready = 1'b1;
                busy     = 1'b0;
                if (tx_valid) begin
                    data_d    = tx_data;
                    par_d     = odd_parity(tx_data);
                    inh_cnt_d = '0;
                    state_d   = INHIBIT;
                end
            end
            INHIBIT: begin
                ps2_clk_oe  = 1'b1;
                ps2_data_oe = inh_last;
                inh_cnt_d   = inh_cnt_q + IW'(1);
                if (inh_last) begin
                    tmo_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = REQ;
                end
            end
            REQ, BITS: begin
                ps2_data_oe = (state_q == REQ) ? 1'b1 : drv_q;
                // bit_cnt_q holds edges already seen: 0-7 data, 8 parity, 9 stop
                if (clk_fall) begin
                    if (bit_cnt_q < 4'd8)
                        drv_d = ~data_q[bit_cnt_q[2:0]];
                    else if (bit_cnt_q == 4'd8)
                        drv_d = ~par_q;
                    else
                        drv_d = 1'b0;
                    bit_cnt_d = (bit_cnt_q == 4'hF) ? bit_cnt_q : bit_cnt_q + 4'd1;
                    if (state_q == REQ)
                        state_d = BITS;
                    else if (bit_cnt_q == 4'd9)
                        state_d = ACK;
                end
            end
            ACK: begin
                if (clk_fall) begin
`ifdef PS2_TX_ACK_CHECK_EN
                    ack_d = ~data_sync;
`endif
                    state_d = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (clk_sync && data_sync) begin
`ifdef PS2_TX_ACK_CHECK_EN
                    done = ack_q;
                    err  = ~ack_q;
`else
                    done = 1'b1;
`endif
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Timeout overrides everything: lines released, err only.
        if (counting && timeout) begin
            ps2_clk_oe  = 1'b0;
            ps2_data_oe = 1'b0;
            done        = 1'b0;
            err         = 1'b1;
            tmo_cnt_d   = '0;
            state_d     = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            data_q    <= '0;
            par_q     <= 1'b0;
            bit_cnt_q <= '0;
            drv_q     <= 1'b0;
            inh_cnt_q <= '0;
            tmo_cnt_q <= '0;
`ifdef PS2_TX_ACK_CHECK_EN
            ack_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            par_q     <= par_d;
            bit_cnt_q <= bit_cnt_d;
            drv_q     <= drv_d;
            inh_cnt_q <= inh_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
`ifdef PS2_TX_ACK_CHECK_EN
            ack_q     <= ack_d;
`endif
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: device model on an open-drain bus, table of commands,
// plus timeout, mid-transfer reset and ignored second request sequences.
module tb_ps2_host_tx;

    localparam int INH  = 1200;
    localparam int TMO  = 3000;
    localparam int HALF = 20;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       dev_clk  = 1'b1;
    logic       dev_data = 1'b1;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       ps2_clk_oe, ps2_data_oe, tx_ready, busy, done, err;

    wire clk_line  = dev_clk  & ~ps2_clk_oe;
    wire data_line = dev_data & ~ps2_data_oe;

    ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk_in  (clk_line),
        .ps2_data_in (data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (done && err) both_cnt++;
    end

    typedef struct {
        logic [10:0] frame;
        logic        exp_done;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [7:0] d;
        bit         ack;
        bit         exp_par;
        bit         exp_done;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk(nm, 32'd1, 32'd0);
    endtask

    // Issue one request and measure the inhibit phase; returns at the first REQ cycle.
    task automatic start_tx(input logic [7:0] d, input bit chk_inh);
        int n = 0;
        int cnt = 0;
        int first = 0;
        @(negedge clk);
        while (!tx_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready) chk("tx_ready_wait", 32'd0, 32'd1);
        @(posedge clk); #1;
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        @(negedge clk);
        while (ps2_clk_oe && cnt < INH + 100) begin
            cnt++;
            if (ps2_data_oe && first == 0) first = cnt;
            @(negedge clk);
        end
        if (chk_inh) begin
            chk("inhibit_len", cnt, INH);
            chk("inhibit_data_last", first, INH);
        end
    endtask

    // Device: clocks 11 falling edges, samples on rising edges, optionally ACKs on edge 11.
    task automatic dev_xfer(input bit ack, input int inj, output logic [10:0] frame, output bit ok);
        int n = 0;
        ok = 1'b1;
        frame = '0;
        while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1 && busy) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) begin
            ok = 1'b0;
            return;
        end
        repeat (10) @(negedge clk);
        frame[0] = data_line;
        for (int e = 1; e <= 11; e++) begin
            if (e == 11 && ack) dev_data = 1'b0;
            dev_clk = 1'b0;
            if (e == inj) begin
                tx_data  = 8'hC3;
                tx_valid = 1'b1;
            end
            repeat (HALF) @(negedge clk);
            tx_valid = 1'b0;
            if (e <= 10) frame[e] = data_line;
            dev_clk = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_data = 1'b1;
        end
    endtask

    task automatic send(input vec_t v, input int inj);
        exp_t        e;
        exp_t        got;
        logic [10:0] frame;
        bit          ok;
        int          d0, e0;
        e.frame    = {1'b1, v.exp_par, v.d, 1'b0};
        e.exp_done = v.exp_done;
        sb.push_back(e);
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(v.d, 1'b1);
        dev_xfer(v.ack, inj, frame, ok);
        chk("req_seen", ok, 1);
        wait_idle("idle_after_xfer");
        repeat (3) @(negedge clk);
        got = sb.pop_front();
        chk("frame", frame, got.frame);
        chk("parity_bit", frame[9], got.frame[9]);
        chk("done_pulses", done_cnt - d0, got.exp_done ? 1 : 0);
        chk("err_pulses", err_cnt - e0, got.exp_done ? 0 : 1);
        chk("tx_ready_after", tx_ready, 1);
    endtask

    initial begin
        int   k;
        int   d0, e0, busy_seen;
        vec_t v;

        vecs[0] = '{8'hED, 1'b1, 1'b1, 1'b1};
        vecs[1] = '{8'h01, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{8'h00, 1'b1, 1'b1, 1'b1};
        vecs[3] = '{8'hFF, 1'b1, 1'b1, 1'b1};
`ifdef PS2_TX_ACK_CHECK_EN
        vecs[4] = '{8'hF4, 1'b0, 1'b0, 1'b0};
`else
        vecs[4] = '{8'hF4, 1'b0, 1'b0, 1'b1};
`endif

        // Reset state
        repeat (4) @(negedge clk);
        chk("rst_clk_oe", ps2_clk_oe, 0);
        chk("rst_data_oe", ps2_data_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done_err", {done, err}, 0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_tx_ready", tx_ready, 1);

        for (int i = 0; i < 5; i++) send(vecs[i], 0);

        // Device never clocks
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(8'hF4, 1'b0);
        k = 0;
        while (!err && k < TMO + 50) begin
            @(negedge clk);
            k++;
        end
        chk("timeout_cycles", k, TMO);
        chk("timeout_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        @(negedge clk);
        chk("timeout_tx_ready", tx_ready, 1);
        chk("timeout_err_once", err_cnt - e0, 1);
        chk("timeout_no_done", done_cnt - d0, 0);

        // Reset after bit 3 is on the bus (0xA5 bit 3 = 0, so data is driven low)
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(8'hA5, 1'b0);
        repeat (10) @(negedge clk);
        for (int e = 1; e <= 4; e++) begin
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            if (e < 4) begin
                dev_clk = 1'b1;
                repeat (HALF) @(negedge clk);
            end
        end
        chk("pre_rst_bit3_driven", ps2_data_oe, 1);
        #2 rst = 1'b0;
        #1;
        chk("midrst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        chk("midrst_busy", busy, 0);
        dev_clk = 1'b1;
        repeat (4) @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("midrst_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
        chk("midrst_tx_ready", tx_ready, 1);
        v = '{8'hF4, 1'b1, 1'b0, 1'b1};
        send(v, 0);

        // Second request during BITS is ignored
        v = '{8'h3C, 1'b1, 1'b1, 1'b1};
        send(v, 5);
        busy_seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (busy) busy_seen++;
        end
        chk("no_second_xfer", busy_seen, 0);

        chk("done_err_overlap", both_cnt, 0);
        chk("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
